// File: rtl/ex_hazard_forward.sv
// EX-stage forwarding and load-use hazard unit.
// Produces per-operand bypass selects from three producers, youngest first:
// EX/MEM, then MEM/WB, then a one-cycle write-back history slot.
// A load-use stall FSM inserts LOAD_LAT stall cycles per hazard.
// A taken branch cancels any stall in progress.
// A saturating counter records how many cycles were stalled.
module ex_hazard_forward #(
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int STAT_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_SRC*REG_W-1:0]   i_ID_EX_rs,
  input  logic [NUM_SRC*REG_W-1:0]   i_IF_ID_rs,
  input  logic                       i_IF_ID_valid,
  input  logic [REG_W-1:0]           i_ID_EX_Rd,
  input  logic                       i_ID_EX_reg_write,
  input  logic                       i_ID_EX_mem_read,
  input  logic [REG_W-1:0]           i_EX_MEM_Rd,
  input  logic                       i_EX_MEM_reg_write,
  input  logic                       i_EX_MEM_mem_read,
  input  logic [REG_W-1:0]           i_MEM_WB_Rd,
  input  logic                       i_MEM_WB_reg_write,
  input  logic                       i_branch_flush,
  output logic [2*NUM_SRC-1:0]       o_forward,
  output logic                       o_stall,
  output logic                       o_flush_ID_EX,
  output logic [STAT_W-1:0]          o_stall_cycles
);

  localparam int CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   hist_valid_r;
  logic [REG_W-1:0]       hist_rd_r;
  logic [STAT_W-1:0]      stall_cnt_r;
  logic                   ex_mem_qual_s;
  logic                   mem_wb_qual_s;
  logic                   hz_match_s;
  logic                   hz_s;
  logic [2*NUM_SRC-1:0]   forward_s;
  logic                   stall_s;
  logic                   flush_id_ex_s;

  // A load in EX/MEM has no result yet, so it must never be a bypass source.
  assign ex_mem_qual_s = i_EX_MEM_reg_write && (i_EX_MEM_Rd != '0) && !i_EX_MEM_mem_read;
  assign mem_wb_qual_s = i_MEM_WB_reg_write && (i_MEM_WB_Rd != '0);

  // Per-operand bypass select, youngest producer wins, x0 always reads the regfile.
  always_comb begin
    forward_s = '0;
    if (!i_rst_n) begin
      forward_s = '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (i_ID_EX_rs[k*REG_W +: REG_W] == '0) begin
          forward_s[2*k +: 2] = 2'b00;
        end else if (ex_mem_qual_s && (i_EX_MEM_Rd == i_ID_EX_rs[k*REG_W +: REG_W])) begin
          forward_s[2*k +: 2] = 2'b01;
        end else if (mem_wb_qual_s && (i_MEM_WB_Rd == i_ID_EX_rs[k*REG_W +: REG_W])) begin
          forward_s[2*k +: 2] = 2'b10;
        end else if (hist_valid_r && (hist_rd_r == i_ID_EX_rs[k*REG_W +: REG_W])) begin
          forward_s[2*k +: 2] = 2'b11;
        end else begin
          forward_s[2*k +: 2] = 2'b00;
        end
      end
    end
  end

  // Load-use detection: any ID-stage source needs the load currently in EX.
  always_comb begin
    hz_match_s = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      hz_match_s = hz_match_s | (i_IF_ID_rs[k*REG_W +: REG_W] == i_ID_EX_Rd);
    end
  end

  assign hz_s = i_ID_EX_mem_read && i_ID_EX_reg_write && (i_ID_EX_Rd != '0)
                && i_IF_ID_valid && hz_match_s;

  // Stall FSM next-state and outputs; branch flush overrides any stall.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    stall_s       = 1'b0;
    flush_id_ex_s = 1'b0;
    if (!i_rst_n) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else if (i_branch_flush) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hz_s) begin
            stall_s       = 1'b1;
            flush_id_ex_s = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt_s = ST_STALL;
              cnt_nxt_s   = CNT_W'(LOAD_LAT - 1);
            end else begin
              state_nxt_s = ST_IDLE;
              cnt_nxt_s   = '0;
            end
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
          end
        end
        ST_STALL: begin
          stall_s       = 1'b1;
          flush_id_ex_s = 1'b1;
          cnt_nxt_s     = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_STALL;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Stall FSM state and remaining-cycle counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // History slot remembers last cycle's write-back so a held instruction still sees it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hist_valid_r <= 1'b0;
      hist_rd_r    <= '0;
    end else begin
      hist_valid_r <= i_MEM_WB_reg_write && (i_MEM_WB_Rd != '0);
      hist_rd_r    <= i_MEM_WB_Rd;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + STAT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_forward      = forward_s;
  assign o_stall        = stall_s;
  assign o_flush_ID_EX  = flush_id_ex_s;
  assign o_stall_cycles = stall_cnt_r;

endmodule

// File: doc/ex_hazard_forward.md
Name: ex_hazard_forward

Overview:
Parametrised forwarding and hazard unit for the EX stage of the pipelined CPU. It generates operand bypass selects for NUM_SRC source operands. The selects cover three producers (EX/MEM, MEM/WB, and a one-cycle write-back history slot) and prioritise the youngest. It also runs a load-use stall FSM with configurable load latency, supports branch-flush cancellation, and keeps a saturating stall-cycle counter.

Parameters:
REG_W, 5, register address width
NUM_SRC, 2, number of source operands per instruction
LOAD_LAT, 1, total stall cycles inserted for a load-use hazard (>=1)
STAT_W, 16, width of the stall-cycle counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active low
i_ID_EX_rs  in  NUM_SRC*REG_W  EX-stage source regs; operand k at bits [k*REG_W +: REG_W]
i_IF_ID_rs  in  NUM_SRC*REG_W  ID-stage source regs, same packing
i_IF_ID_valid  in  1  ID-stage instruction valid
i_ID_EX_Rd  in  REG_W  EX-stage destination
i_ID_EX_reg_write  in  1  EX-stage writes register
i_ID_EX_mem_read  in  1  EX-stage instruction is a load
i_EX_MEM_Rd  in  REG_W  MEM-stage destination
i_EX_MEM_reg_write  in  1  MEM-stage writes register
i_EX_MEM_mem_read  in  1  MEM-stage instruction is a load (result not yet available)
i_MEM_WB_Rd  in  REG_W  WB-stage destination
i_MEM_WB_reg_write  in  1  WB-stage writes register
i_branch_flush  in  1  branch resolved taken; younger stages flushed
o_forward  out  2*NUM_SRC  per-operand select, operand k at [2k +: 2]
o_stall  out  1  hold PC and IF/ID register
o_flush_ID_EX  out  1  insert bubble into ID/EX
o_stall_cycles  out  STAT_W  saturating count of cycles with o_stall=1

Behaviour:
- Reset (i_rst_n=0 at posedge): FSM to IDLE, history slot invalid, stall counter 0. While i_rst_n=0, o_forward=0, o_stall=0, o_flush_ID_EX=0, all forced combinationally.
- Producer qualifiers:
  - EX/MEM qualifies when reg_write=1, Rd!=0 and i_EX_MEM_mem_read=0.
  - MEM/WB qualifies when reg_write=1 and Rd!=0.
  - History slot qualifies when its valid bit=1.
- History slot: each posedge, it captures {valid=i_MEM_WB_reg_write && i_MEM_WB_Rd!=0, Rd=i_MEM_WB_Rd}. It covers the regfile write-then-read window for the instruction held by a stall.
- o_forward per operand, combinational, with priority 01 > 10 > 11 > 00:
  - 01: EX/MEM qualifies and Rd matches.
  - 10: MEM/WB qualifies and Rd matches.
  - 11: history qualifies and Rd matches.
  - 00: register file.
  - Source reg 0 always yields 00.
- Load-use detect (combinational):
  - hz = i_ID_EX_mem_read && i_ID_EX_reg_write && i_ID_EX_Rd!=0 && i_IF_ID_valid && (any i_IF_ID_rs[k]==i_ID_EX_Rd).
- FSM with states IDLE and STALL, plus internal counter cnt (width clog2(LOAD_LAT+1)):
  - IDLE: if hz && !i_branch_flush, assert o_stall=1 and o_flush_ID_EX=1 this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1. Otherwise remain in IDLE.
  - STALL: o_stall=1 and o_flush_ID_EX=1. cnt decrements each cycle; when cnt==1, next state is IDLE.
  - Total stall per hazard is exactly LOAD_LAT cycles.
- i_branch_flush dominates:
  - In any state, o_stall=0 and o_flush_ID_EX=0 that cycle.
  - Next state is IDLE and cnt is cleared.
  - o_forward is unaffected.
- o_stall_cycles increments on every posedge where o_stall=1 and saturates at 2^STAT_W-1.
- Forwarding and stall logic are independent. A stalled ID instruction's later EX-stage selects come from the normal rules at that time.

Test Plan:
- Back-to-back ALU: EX_MEM_Rd=3 with reg_write, MEM_WB_Rd=3 with reg_write, ID_EX_rs={3,3} -> o_forward=4'b0101. Same case with EX_MEM_reg_write=0 -> 4'b1010.
- Zero register: all Rd=0 and rs=0 with reg_write=1 -> o_forward=0 and no stall.
- Load-use, LOAD_LAT=1: ID_EX load Rd=5, IF_ID_rs[0]=5 -> o_stall=1 and o_flush_ID_EX=1 for exactly 1 cycle. Next cycle EX_MEM_Rd=5 with mem_read=0 -> operand 0 select 01. o_stall_cycles=1.
- Load-use, LOAD_LAT=3: same stimulus -> stall for exactly 3 cycles. The history slot provides select 11 when the retired Rd matches after WB.
- Branch flush mid-stall (LOAD_LAT=3): assert i_branch_flush in stall cycle 2 -> o_stall=0 that cycle, FSM IDLE next cycle, counter=1.
- Reset mid-STALL, then counter saturation with STAT_W=2:
  - Reset during STALL -> all outputs 0, IDLE, history invalid, counter 0.
  - Stall for 5 cycles -> counter holds 3.
